// File: rtl/dlatch_monitor.sv
// rtl/dlatch_monitor.sv - debounced, complementarity-checked monitor for a D-latch Q/Q-bar rail pair
module dlatch_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int STABLE_CYCLES  = 4,
    parameter int ILLEGAL_CYCLES = 3,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 q_in,
    input  logic                 qn_in,
    input  logic                 clear,
    output logic                 q_stable,
    output logic                 q_rise,
    output logic                 q_fall,
    output logic [CNT_WIDTH-1:0] toggle_count,
    output logic                 count_sat,
    output logic                 valid,
    output logic                 illegal
);

    // The FSM registers capture alongside the final synchronizer stage, so the
    // explicit chain holds SYNC_STAGES-1 flops and qs/qns are its output.
    localparam int SW   = SYNC_STAGES - 1;
    localparam int CMAX = (STABLE_CYCLES > ILLEGAL_CYCLES) ? STABLE_CYCLES : ILLEGAL_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] STABLE_N = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] ILL_N    = CW'(ILLEGAL_CYCLES);
    localparam logic [CW-1:0] ONE_N    = CW'(1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_STABLE = 2'd1,
        S_SETTLE = 2'd2,
        S_FAULT  = 2'd3
    } state_t;

    logic [SW-1:0]        q_sync;
    logic [SW-1:0]        qn_sync;
    logic                 qs;
    logic                 qns;
    logic                 legal;

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        run_cnt;
    logic [CW-1:0]        run_cnt_n;
    logic [CW-1:0]        run_inc;
    logic                 run_val;
    logic                 run_val_n;
    logic [CW-1:0]        ill_cnt;
    logic [CW-1:0]        ill_next;
    logic                 commit;
    logic                 acquire;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign qs      = q_sync[SW-1];
    assign qns     = qn_sync[SW-1];
    assign legal   = qs ^ qns;
    assign cnt_inc = toggle_count + 1'b1;

    always_comb begin
        ill_next  = ill_cnt;
        run_inc   = ONE_N;
        state_n   = state;
        run_cnt_n = run_cnt;
        run_val_n = run_val;
        commit    = 1'b0;
        acquire   = 1'b0;

        if (legal) begin
            ill_next = '0;
        end else if (ill_cnt != ILL_N) begin
            ill_next = ill_cnt + 1'b1;
        end

        if (run_cnt != '0 && qs == run_val) begin
            run_inc = run_cnt + 1'b1;
        end

        if (state != S_FAULT && !legal && ill_next == ILL_N) begin
            state_n   = S_FAULT;
            run_cnt_n = '0;
        end else begin
            case (state)
                S_INIT, S_FAULT: begin
                    if (legal) begin
                        run_cnt_n = run_inc;
                        run_val_n = qs;
                        if (run_inc == STABLE_N) begin
                            state_n   = S_STABLE;
                            run_cnt_n = '0;
                            // Leaving FAULT at a new level is a real toggle; leaving INIT is not.
                            if (state == S_INIT) begin
                                acquire = 1'b1;
                            end else if (qs != q_stable) begin
                                commit = 1'b1;
                            end
                        end
                    end else begin
                        run_cnt_n = '0;
                    end
                end
                S_STABLE: begin
                    if (legal && qs != q_stable) begin
                        run_val_n = qs;
                        run_cnt_n = ONE_N;
                        if (STABLE_N == ONE_N) begin
                            commit    = 1'b1;
                            run_cnt_n = '0;
                        end else begin
                            state_n = S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (!legal || qs == q_stable) begin
                        state_n   = S_STABLE;
                        run_cnt_n = '0;
                    end else begin
                        run_cnt_n = run_cnt + 1'b1;
                        if (run_cnt_n == STABLE_N) begin
                            commit    = 1'b1;
                            state_n   = S_STABLE;
                            run_cnt_n = '0;
                        end
                    end
                end
                default: begin
                    state_n   = S_INIT;
                    run_cnt_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_sync       <= '0;
            qn_sync      <= '1;
            state        <= S_INIT;
            run_cnt      <= '0;
            run_val      <= 1'b0;
            ill_cnt      <= '0;
            q_stable     <= 1'b0;
            q_rise       <= 1'b0;
            q_fall       <= 1'b0;
            valid        <= 1'b0;
            illegal      <= 1'b0;
            toggle_count <= '0;
            count_sat    <= 1'b0;
        end else begin
            q_sync[0]  <= q_in;
            qn_sync[0] <= qn_in;
            for (int i = 1; i < SW; i++) begin
                q_sync[i]  <= q_sync[i-1];
                qn_sync[i] <= qn_sync[i-1];
            end

            state   <= state_n;
            run_cnt <= run_cnt_n;
            run_val <= run_val_n;
            ill_cnt <= ill_next;

            if (acquire || commit) begin
                q_stable <= qs;
            end
            q_rise  <= commit & qs;
            q_fall  <= commit & ~qs;
            valid   <= (state_n == S_STABLE) || (state_n == S_SETTLE);
            illegal <= (state_n == S_FAULT);

            if (clear) begin
                toggle_count <= '0;
                count_sat    <= 1'b0;
            end else if (commit && !count_sat) begin
                toggle_count <= cnt_inc;
                count_sat    <= &cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_dlatch_monitor.sv
// tb/tb_dlatch_monitor.sv - directed self-checking bench for dlatch_monitor
module tb_dlatch_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       q_in = 1'b0;
    logic       qn_in = 1'b1;
    logic       clear = 1'b0;

    logic       q_stable, q_rise, q_fall, count_sat, valid, illegal;
    logic [7:0] toggle_count;
    logic       b_q_stable, b_q_rise, b_q_fall, b_count_sat, b_valid, b_illegal;
    logic [1:0] b_toggle_count;
    logic [5:0] flags;

    int checks = 0;
    int failures = 0;

    dlatch_monitor dut (
        .clk(clk), .rst(rst), .q_in(q_in), .qn_in(qn_in), .clear(clear),
        .q_stable(q_stable), .q_rise(q_rise), .q_fall(q_fall),
        .toggle_count(toggle_count), .count_sat(count_sat),
        .valid(valid), .illegal(illegal)
    );

    dlatch_monitor #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .q_in(q_in), .qn_in(qn_in), .clear(clear),
        .q_stable(b_q_stable), .q_rise(b_q_rise), .q_fall(b_q_fall),
        .toggle_count(b_toggle_count), .count_sat(b_count_sat),
        .valid(b_valid), .illegal(b_illegal)
    );

    // {q_stable, valid, illegal, q_rise, q_fall, count_sat}
    assign flags = {q_stable, valid, illegal, q_rise, q_fall, count_sat};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acquire0();
        int n;
        rst = 1'b1; clear = 1'b0; q_in = 1'b0; qn_in = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n = 0;
        while (!valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (valid !== 1'b1 || q_stable !== 1'b0) begin
            failures++;
            $display("FAIL acquire0 valid=%0b q_stable=%0b required valid=1 q_stable=0", valid, q_stable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; q_in = 1'b1; qn_in = 1'b0;
        tick(); tick();
        checks++;
        if (flags !== 6'b000000 || toggle_count !== 8'd0) begin
            failures++;
            $display("FAIL reset flags=%b count=%0d required flags=000000 count=0", flags, toggle_count);
        end
    endtask

    task automatic test_acquire();
        logic [5:0] exp;
        rst = 1'b0; q_in = 1'b1; qn_in = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp = (i >= 5) ? 6'b110000 : 6'b000000;
            checks++;
            if (flags !== exp || toggle_count !== 8'd0) begin
                failures++;
                $display("FAIL acquire edge%0d flags=%b count=%0d required flags=%b count=0",
                         i, flags, toggle_count, exp);
            end
        end
    endtask

    task automatic test_rise();
        logic [5:0] exp;
        logic [7:0] exp_cnt;
        acquire0();
        q_in = 1'b1; qn_in = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            exp     = (i < 5) ? 6'b010000 : (i == 5) ? 6'b110100 : 6'b110000;
            exp_cnt = (i >= 5) ? 8'd1 : 8'd0;
            checks++;
            if (flags !== exp || toggle_count !== exp_cnt) begin
                failures++;
                $display("FAIL rise edge%0d flags=%b count=%0d required flags=%b count=%0d",
                         i, flags, toggle_count, exp, exp_cnt);
            end
        end
    endtask

    task automatic test_glitch();
        acquire0();
        q_in = 1'b1; qn_in = 1'b0;
        tick(); tick(); tick();
        q_in = 1'b0; qn_in = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (flags !== 6'b010000 || toggle_count !== 8'd0) begin
                failures++;
                $display("FAIL glitch cycle%0d flags=%b count=%0d required flags=010000 count=0",
                         i, flags, toggle_count);
            end
        end
    endtask

    task automatic test_fault();
        acquire0();
        q_in = 1'b1; qn_in = 1'b1;
        tick(); tick();
        q_in = 1'b0; qn_in = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (flags !== 6'b010000) begin
                failures++;
                $display("FAIL short_illegal cycle%0d flags=%b required 010000", i, flags);
            end
        end
        q_in = 1'b1; qn_in = 1'b1;
        tick(); tick(); tick();
        q_in = 1'b1; qn_in = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (flags !== 6'b001000) begin
                failures++;
                $display("FAIL fault cycle%0d flags=%b required 001000", i, flags);
            end
        end
        tick();
        checks++;
        if (flags !== 6'b110100 || toggle_count !== 8'd1) begin
            failures++;
            $display("FAIL fault_recover flags=%b count=%0d required flags=110100 count=1", flags, toggle_count);
        end
        tick();
        checks++;
        if (flags !== 6'b110000) begin
            failures++;
            $display("FAIL fault_pulse_end flags=%b required 110000", flags);
        end
    endtask

    task automatic test_saturate();
        logic       v;
        logic [1:0] exp_b;
        acquire0();
        for (int k = 0; k < 5; k++) begin
            v = (k % 2 == 0);
            q_in = v; qn_in = ~v;
            repeat (6) tick();
            exp_b = (k + 1 >= 3) ? 2'd3 : 2'(k + 1);
            checks++;
            if (b_toggle_count !== exp_b || b_count_sat !== (k + 1 >= 3) ||
                toggle_count !== 8'(k + 1) || count_sat !== 1'b0) begin
                failures++;
                $display("FAIL saturate toggle%0d b_count=%0d b_sat=%0b count=%0d sat=%0b required b_count=%0d b_sat=%0b count=%0d sat=0",
                         k + 1, b_toggle_count, b_count_sat, toggle_count, count_sat,
                         exp_b, (k + 1 >= 3), k + 1);
            end
        end
        q_in = 1'b0; qn_in = 1'b1;
        repeat (4) tick();
        clear = 1'b1;
        tick();
        checks++;
        if (b_toggle_count !== 2'd0 || b_count_sat !== 1'b0 || toggle_count !== 8'd0 ||
            q_fall !== 1'b1 || b_q_fall !== 1'b1) begin
            failures++;
            $display("FAIL clear_commit b_count=%0d b_sat=%0b count=%0d q_fall=%0b b_q_fall=%0b required 0 0 0 1 1",
                     b_toggle_count, b_count_sat, toggle_count, q_fall, b_q_fall);
        end
        clear = 1'b0;
        tick();
        checks++;
        if (q_fall !== 1'b0 || toggle_count !== 8'd0 || b_toggle_count !== 2'd0) begin
            failures++;
            $display("FAIL clear_after q_fall=%0b count=%0d b_count=%0d required 0 0 0",
                     q_fall, toggle_count, b_toggle_count);
        end
    endtask

    task automatic test_rst_settle();
        acquire0();
        q_in = 1'b1; qn_in = 1'b0;
        repeat (6) tick();
        q_in = 1'b0; qn_in = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (flags !== 6'b000000 || toggle_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_settle flags=%b count=%0d required flags=000000 count=0", flags, toggle_count);
        end
        tick();
        checks++;
        if (flags !== 6'b000000) begin
            failures++;
            $display("FAIL rst_settle_hold flags=%b required 000000", flags);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_settle_init valid=%0b required 0", valid);
        end
        for (int i = 1; i <= 6; i++) begin
            tick();
            checks++;
            if (q_rise !== 1'b0 || q_fall !== 1'b0 || toggle_count !== 8'd0) begin
                failures++;
                $display("FAIL rst_settle_nopulse cycle%0d rise=%0b fall=%0b count=%0d required 0 0 0",
                         i, q_rise, q_fall, toggle_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_rise();
        test_glitch();
        test_fault();
        test_saturate();
        test_rst_settle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
